vram_console: RTL and testbench
===============================

VRAM_CONSOLE -- requirements
Module: vram_console

Interface
REQ-001 SHALL provide parameter COLS, default 40, text columns per row.
REQ-002 SHALL provide parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL provide parameter BLANK, default 8'h20, fill code written by clears.
REQ-004 SHALL provide port clk, input, 1, single clock for all logic.
REQ-005 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port char_valid, input, 1, requester has a character code.
REQ-007 SHALL provide port char_data, input, 8, character code.
REQ-008 SHALL provide port char_ready, output, 1, character accepted this cycle when char_valid is also high.
REQ-009 SHALL provide port clear, input, 1, single-cycle pulse requesting a full-screen clear.
REQ-010 SHALL provide port vram_waddr, output, 11, VRAM write address (row*COLS+col).
REQ-011 SHALL provide port vram_wdata, output, 8, VRAM write data.
REQ-012 SHALL provide port vram_we, output, 1, VRAM write strobe, one write per cycle.
REQ-013 SHALL provide ports cursor_x (6 bits) and cursor_y (5 bits), outputs, current cursor column and row.
REQ-014 SHALL provide port busy, output, 1, high whenever state is not IDLE.

Function
REQ-015 SHALL implement states IDLE, CLRLINE and CLRSCR.
REQ-016 SHALL drive char_ready = (state==IDLE) && !clear, combinationally; all other outputs SHALL be registered.
REQ-017 SHALL, on accept (char_valid && char_ready) in cycle N of a code 8'h20..8'hFF, assert vram_we in N+1 with waddr = cursor_y*COLS+cursor_x (cursor as sampled in N) and wdata = char_data.
REQ-018 SHALL then advance the cursor: x+1 if x<COLS-1; otherwise x=0, y=y+1 (y=ROWS-1 wraps to 0), and enter CLRLINE for the new row.
REQ-019 SHALL treat 8'h0A (LF) as: no write, x=0, y advanced with wrap as REQ-018, enter CLRLINE.
REQ-020 SHALL treat 8'h0D (CR) as: no write, x=0, y unchanged, remain IDLE.
REQ-021 SHALL treat 8'h08 (BS) as: no write, x=x-1 if x>0 else unchanged, remain IDLE.
REQ-022 SHALL accept and discard all other codes below 8'h20 with no write and no cursor change.
REQ-023 SHALL, in CLRLINE, issue exactly COLS writes of BLANK to columns 0..COLS-1 of cursor_y on consecutive cycles; a line clear entered after an accept in cycle N SHALL occupy CLRLINE during N+1..N+COLS, put vram_we high during N+2..N+COLS+1, and return to IDLE (char_ready=1) at N+COLS+1.
REQ-024 SHALL, on clear high in any state, enter CLRSCR next cycle and write BLANK to addresses 0..COLS*ROWS-1 in ascending order, one per cycle, then set cursor to (0,0) and return to IDLE.
REQ-025 SHALL give clear priority over char_valid in IDLE (no accept that cycle).
REQ-026 SHALL let clear during CLRLINE abort the line clear and start CLRSCR at address 0.
REQ-027 SHALL let clear during CLRSCR restart the screen clear at address 0.
REQ-028 SHALL hold vram_we low in every cycle not specified above; vram_waddr and vram_wdata are don't-care when vram_we is low.
REQ-029 SHALL never present vram_waddr >= COLS*ROWS with vram_we high.
REQ-030 SHALL compute addresses without a multiplier (e.g. y*32+y*8+x for COLS=40); widths SHALL hold 1199 in 11 bits without overflow.

Reset
REQ-031 SHALL, while rst_n is low, force vram_we=0, cursor_x=0, cursor_y=0, busy=1, char_ready=0.
REQ-032 SHALL enter CLRSCR at address 0 on rst_n deassertion, so the screen is blanked after every reset.
REQ-033 SHALL, if rst_n asserts mid-operation, abandon the operation immediately; the remaining writes are not issued.

Verification
REQ-034 SHALL check: release reset -> exactly 1200 writes of 8'h20 at addresses 0..1199 ascending, then busy=0 and char_ready=1 with cursor (0,0).
REQ-035 SHALL check: after idle, send 'A','B' back-to-back -> writes (0,8'h41),(1,8'h42) on consecutive cycles, cursor_x=2.
REQ-036 SHALL check: cursor (39,5), send 'Z' at N -> write (239,8'h5A) at N+1, then 40 writes of 8'h20 to addresses 240..279 at N+2..N+41, char_ready=1 at N+41, cursor (0,6).
REQ-037 SHALL check: cursor (7,29), send 8'h0A -> cursor (0,0) and line clear of addresses 0..39; send 8'h08 at x=0 -> no change; send 8'h0D at x=7 -> x=0, no write.
REQ-038 SHALL check: clear and char_valid high in the same IDLE cycle -> no accept; CLRSCR starts; clear reasserted mid-CLRSCR -> address restarts at 0.
REQ-039 SHALL check: rst_n asserted mid-CLRLINE -> vram_we low immediately; after release a full 1200-write clear runs.

Source files
------------

// File: rtl/vram_console.sv
// Text console front-end for a character VRAM: accepts character codes, keeps a cursor,
// and blanks lines and the whole screen one VRAM write per cycle.
module vram_console #(
  parameter int          COLS  = 40,
  parameter int          ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        clear,
  output logic [10:0] vram_waddr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic [5:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CLRLINE = 2'd1;
  localparam logic [1:0] CLRSCR  = 2'd2;

  localparam logic [10:0] SCR_LAST = 11'(COLS * ROWS - 1);
  localparam logic [10:0] COLS_W   = 11'(COLS);
  localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);

  logic [1:0]  state;
  logic [10:0] row_base;
  logic [10:0] clr_addr;
  logic [5:0]  clr_col;
  logic [4:0]  next_y;
  logic [10:0] next_base;
  logic        printable;
  logic        newline;

  assign char_ready = (state == IDLE) && !clear;
  assign printable  = (char_data >= 8'h20);
  assign newline    = (printable && (cursor_x == COL_LAST)) || (char_data == 8'h0A);

  // row_base always equals cursor_y*COLS, so addresses need only an adder
  always_comb begin
    next_y    = cursor_y + 5'd1;
    next_base = row_base + COLS_W;
    if (cursor_y == ROW_LAST) begin
      next_y    = 5'd0;
      next_base = 11'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLRSCR;
      busy       <= 1'b1;
      vram_we    <= 1'b0;
      vram_waddr <= 11'd0;
      vram_wdata <= 8'd0;
      cursor_x   <= 6'd0;
      cursor_y   <= 5'd0;
      row_base   <= 11'd0;
      clr_addr   <= 11'd0;
      clr_col    <= 6'd0;
    end else begin
      vram_we <= 1'b0;
      if (clear) begin
        state    <= CLRSCR;
        busy     <= 1'b1;
        clr_addr <= 11'd0;
      end else begin
        case (state)
          IDLE: begin
            if (char_valid) begin
              if (printable) begin
                vram_we    <= 1'b1;
                vram_waddr <= row_base + {5'd0, cursor_x};
                vram_wdata <= char_data;
              end
              if (newline) begin
                cursor_x <= 6'd0;
                cursor_y <= next_y;
                row_base <= next_base;
                clr_col  <= 6'd0;
                state    <= CLRLINE;
                busy     <= 1'b1;
              end else if (printable) begin
                cursor_x <= cursor_x + 6'd1;
              end else if (char_data == 8'h0D) begin
                cursor_x <= 6'd0;
              end else if ((char_data == 8'h08) && (cursor_x != 6'd0)) begin
                cursor_x <= cursor_x - 6'd1;
              end
            end
          end
          CLRLINE: begin
            vram_we    <= 1'b1;
            vram_waddr <= row_base + {5'd0, clr_col};
            vram_wdata <= BLANK;
            if (clr_col == COL_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              clr_col <= clr_col + 6'd1;
            end
          end
          CLRSCR: begin
            vram_we    <= 1'b1;
            vram_waddr <= clr_addr;
            vram_wdata <= BLANK;
            if (clr_addr == SCR_LAST) begin
              state    <= IDLE;
              busy     <= 1'b0;
              cursor_x <= 6'd0;
              cursor_y <= 5'd0;
              row_base <= 11'd0;
            end else begin
              clr_addr <= clr_addr + 11'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vram_console.sv
// Scoreboard bench for vram_console: a cursor/screen model predicts every VRAM write
// with its cycle, and a negedge monitor compares what the DUT actually writes.
module tb_vram_console;

  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int SCR  = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_data = 8'h00;
  logic        clear = 1'b0;
  logic        char_ready;
  logic [10:0] vram_waddr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [5:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  vram_console #(.COLS(COLS), .ROWS(ROWS), .BLANK(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .clear(clear), .vram_waddr(vram_waddr),
    .vram_wdata(vram_wdata), .vram_we(vram_we), .cursor_x(cursor_x),
    .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passed = 0;
  int  mx = 0;
  int  my = 0;
  int  exp_idle = 0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  // Every DUT write must match the oldest predicted write, including its cycle
  wr_t e;
  always @(negedge clk) begin
    if (rst_n && vram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_write: addr %0d data %0h at cycle %0d, none expected",
                 vram_waddr, vram_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        if (vram_waddr == e.addr[10:0] && vram_wdata == e.data[7:0] && cyc == e.cyc)
          passed++;
        else
          $display("[TB] FAIL write: got addr %0d data %0h cycle %0d, expected addr %0d data %0h cycle %0d",
                   vram_waddr, vram_wdata, cyc, e.addr, e.data, e.cyc);
      end
    end
  end

  task automatic push_line(input int row, input int start);
    for (int i = 0; i < COLS; i++) exp_q.push_back('{row * COLS + i, 'h20, start + i});
  endtask

  task automatic push_screen(input int start);
    exp_q.delete();
    for (int a = 0; a < SCR; a++) exp_q.push_back('{a, 'h20, start + a});
  endtask

  // Reference behaviour of one accepted code in cycle n
  task automatic model_accept(input int code, input int n);
    exp_idle = n + 1;
    if (code >= 'h20) begin
      exp_q.push_back('{my * COLS + mx, code, n + 1});
      if (mx < COLS - 1) mx++;
      else begin
        mx = 0; my = (my + 1) % ROWS;
        push_line(my, n + 2); exp_idle = n + COLS + 1;
      end
    end else if (code == 'h0A) begin
      mx = 0; my = (my + 1) % ROWS;
      push_line(my, n + 2); exp_idle = n + COLS + 1;
    end else if (code == 'h0D) begin
      mx = 0;
    end else if (code == 'h08) begin
      if (mx > 0) mx--;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] code);
    int n;
    int guard;
    char_valid = 1'b1;
    char_data  = code;
    guard = 0;
    @(negedge clk);
    while (!char_ready && guard < SCR + 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", char_ready, 1);
    n = cyc;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    if (n >= 0 && guard < SCR + 100) model_accept(code, n);
  endtask

  task automatic apply_clear(input bit with_char);
    int c;
    clear = 1'b1;
    if (with_char) begin
      char_valid = 1'b1;
      char_data  = 8'h41;
    end
    @(negedge clk);
    c = cyc;
    check("ready_low_on_clear", char_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    char_valid = 1'b0;
    push_screen(c + 2);
    exp_idle = c + 1 + SCR;
    mx = 0;
    my = 0;
  endtask

  task automatic apply_reset();
    int r;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("reset_we", vram_we, 0);
    check("reset_busy", busy, 1);
    check("reset_ready", char_ready, 0);
    check("reset_cx", cursor_x, 0);
    check("reset_cy", cursor_y, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    push_screen(r + 1);
    exp_idle = r + SCR;
    mx = 0;
    my = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!char_ready && guard < SCR + 100) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_idle_cycle"}, cyc, exp_idle);
    check({name, "_cx"}, cursor_x, mx);
    check({name, "_cy"}, cursor_y, my);
    check({name, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int code;
    #2;
    apply_reset();
    check_output("reset");

    apply_stimulus(8'h41);
    apply_stimulus(8'h42);
    check_output("ab");

    apply_clear(1'b0);
    check_output("clear");
    repeat (5) apply_stimulus(8'h0A);
    for (int i = 0; i < COLS - 1; i++) apply_stimulus(8'h30 + 8'(i % 10));
    check_output("at_39_5");
    apply_stimulus(8'h5A);
    check_output("wrap_z");

    repeat (23) apply_stimulus(8'h0A);
    for (int i = 0; i < 7; i++) apply_stimulus(8'h61 + 8'(i));
    check_output("at_7_29");
    apply_stimulus(8'h0A);
    check_output("lf_wrap");
    apply_stimulus(8'h08);
    check_output("bs_x0");
    for (int i = 0; i < 7; i++) apply_stimulus(8'h61 + 8'(i));
    apply_stimulus(8'h0D);
    check_output("cr");

    apply_clear(1'b1);
    repeat (100) @(posedge clk);
    #1;
    apply_clear(1'b0);
    check_output("clear_restart");

    apply_stimulus(8'h0A);
    repeat (10) @(posedge clk);
    #1;
    apply_reset();
    check_output("reset_mid_line");

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      code = $urandom_range(32, 255);
      else if (r < 80) code = 'h0A;
      else if (r < 85) code = 'h0D;
      else if (r < 92) code = 'h08;
      else begin
        code = $urandom_range(0, 31);
        if (code == 'h08 || code == 'h0A || code == 'h0D) code = 'h01;
      end
      apply_stimulus(8'(code));
      if ($urandom_range(0, 99) < 2) apply_clear(1'b1);
      if ($urandom_range(0, 1) == 1) check_output("random");
    end
    check_output("final");
    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
